// File: rtl/knap_result_tx.sv
// Serializes the knapsack DP result table as a framed UART 8N1 stream:
// A5, length, table[0..L-1], checksum (length + data, mod 256).
module knap_result_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_CAP      = 64,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        tbl_len,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    output logic              tx_serial,
    output logic              busy,
    output logic              done
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {IDLE, HDR, LEN, DATA, CSUM, FINISH} state_t;

    state_t            state_q;
    logic [BW-1:0]     baud_q;
    logic [3:0]        bit_q;
    logic [7:0]        sh_q, len_q, csum_q, nxt_q, dcnt_q;
    logic              have_q, cap_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_en_q, tx_q, busy_q, done_q;

    logic       baud_end_d, enter_stop_d, byte_end_d, pf_d;
    logic [7:0] len_d;

    assign baud_end_d   = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign enter_stop_d = baud_end_d && (bit_q == 4'd8);
    assign byte_end_d   = baud_end_d && (bit_q == 4'd9);
    // Fetch the next data byte as the current LEN/DATA byte enters its stop bit.
    assign pf_d  = enter_stop_d && (state_q == LEN || state_q == DATA) && (dcnt_q < len_q);
    assign len_d = (tbl_len > 8'(MAX_CAP)) ? 8'(MAX_CAP) : tbl_len;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            len_q     <= '0;
            csum_q    <= '0;
            nxt_q     <= '0;
            dcnt_q    <= '0;
            have_q    <= 1'b0;
            cap_q     <= 1'b0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            cap_q   <= rd_en_q;
            done_q  <= 1'b0;
            // Synchronous table: data is valid the cycle after the strobe.
            if (cap_q) begin
                nxt_q  <= rd_data;
                csum_q <= csum_q + rd_data;
                have_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= HDR;
                        busy_q  <= 1'b1;
                        tx_q    <= 1'b0;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        sh_q    <= 8'hA5;
                        len_q   <= len_d;
                        csum_q  <= '0;
                        dcnt_q  <= '0;
                        have_q  <= 1'b0;
                    end
                end
                default: begin
                    baud_q <= baud_end_d ? '0 : baud_q + 1'b1;
                    if (baud_end_d) begin
                        if (bit_q == 4'd9) begin
                            bit_q <= '0;
                            tx_q  <= 1'b0;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                            tx_q  <= (bit_q == 4'd8) ? 1'b1 : sh_q[bit_q[2:0]];
                        end
                    end
                    if (pf_d) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= dcnt_q[ADDR_W-1:0];
                        dcnt_q    <= dcnt_q + 8'd1;
                    end
                    if (enter_stop_d && state_q == CSUM)
                        state_q <= FINISH;
                    if (byte_end_d) begin
                        case (state_q)
                            HDR: begin
                                state_q <= LEN;
                                sh_q    <= len_q;
                                csum_q  <= csum_q + len_q;
                            end
                            LEN, DATA: begin
                                if (have_q) begin
                                    state_q <= DATA;
                                    sh_q    <= nxt_q;
                                    have_q  <= 1'b0;
                                end else begin
                                    state_q <= CSUM;
                                    sh_q    <= csum_q;
                                end
                            end
                            FINISH: begin
                                state_q <= IDLE;
                                tx_q    <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign rd_addr   = rd_addr_q;
    assign rd_en     = rd_en_q;
    assign tx_serial = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_knap_result_tx.sv
// Scoreboard bench for knap_result_tx: stimulus queues expected bytes/frames,
// a negedge monitor decodes the UART line and checks reads, timing and done.
module tb_knap_result_tx;
    localparam int CPB = 4, MAXC = 64, AW = 6;

    logic          clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [7:0]    tbl_len = 8'd0, rd_data = 8'd0;
    logic [AW-1:0] rd_addr;
    logic          rd_en, tx_serial, busy, done;

    always #5 clk = ~clk;

    knap_result_tx #(.CLKS_PER_BIT(CPB), .MAX_CAP(MAXC), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .tbl_len(tbl_len),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .tx_serial(tx_serial), .busy(busy), .done(done)
    );

    // Synchronous table; garbage on the bus whenever not reading.
    logic [7:0] mem [0:MAXC-1];
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'($urandom);

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct { logic [7:0] b; bit last; } exp_byte_t;
    typedef struct { int lat; int nrd; } exp_frm_t;
    exp_byte_t bq[$];
    exp_frm_t  fq[$];

    task automatic push_byte(input logic [7:0] b, input bit last);
        exp_byte_t e;
        e.b = b; e.last = last;
        bq.push_back(e);
    endtask

    task automatic push_frame(input int L, input logic [7:0] cs);
        exp_frm_t f;
        push_byte(8'hA5, 1'b0);
        push_byte(8'(L), 1'b0);
        for (int i = 0; i < L; i++) push_byte(mem[i], 1'b0);
        push_byte(cs, 1'b1);
        f.lat = (L + 3) * 10 * CPB; f.nrd = L;
        fq.push_back(f);
    endtask

    // Monitor state
    int         cyc = 0, mst = 0, mbit = 0, mcnt = 0;
    logic       bv = 1'b1;
    logic [7:0] cur = 8'd0;
    bit         glitch = 0, exp_next = 0, fact = 0;
    int         fstart = 0, nrd = 0, busy_low = 0, done_cnt = 0, rd_next = 0;

    always @(negedge clk) begin
        exp_byte_t e;
        exp_frm_t  f;
        cyc++;
        if (!reset) begin
            mst = 0; fact = 0; exp_next = 0;
        end else begin
            if (mst == 1) begin
                if (mcnt == CPB) begin
                    mbit++; mcnt = 1; bv = tx_serial;
                end else begin
                    mcnt++;
                    if (tx_serial !== bv) glitch = 1;
                end
            end else if (tx_serial == 1'b0) begin
                mst = 1; mbit = 0; mcnt = 1; bv = 1'b0; glitch = 0;
                exp_next = 0;
                if (!fact) begin
                    fact = 1; fstart = cyc; nrd = 0; busy_low = 0; rd_next = 0;
                end
            end else if (exp_next) begin
                chk("byte_gap", int'(tx_serial), 0);
                exp_next = 0;
            end
            if (mst == 1 && mcnt == CPB) begin
                if (mbit >= 1 && mbit <= 8) cur[mbit-1] = bv;
                if (mbit == 9) begin
                    chk("stop_bit", int'(bv), 1);
                    chk("bit_width_glitch", int'(glitch), 0);
                    chk("byte_expected", int'(bq.size() > 0), 1);
                    if (bq.size() > 0) begin
                        e = bq.pop_front();
                        chk("byte", int'(cur), int'(e.b));
                        exp_next = !e.last;
                    end
                    mst = 0;
                end
            end
            if (rd_en) begin
                chk("rd_phase_first_stop_cycle", int'(mst == 1 && mbit == 9 && mcnt == 1), 1);
                chk("rd_addr", int'(rd_addr), rd_next);
                rd_next++; nrd++;
            end
            if (done) begin
                done_cnt++;
                chk("frame_expected", int'(fq.size() > 0), 1);
                if (fq.size() > 0) begin
                    f = fq.pop_front();
                    chk("latency", cyc - fstart, f.lat);
                    chk("read_count", nrd, f.nrd);
                end
                chk("busy_low_in_frame", busy_low, 0);
                chk("tx_idle_at_done", int'(tx_serial), 1);
                fact = 0;
            end else if (fact && !busy) begin
                busy_low++;
            end
        end
    end

    task automatic kick();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_on_accept", int'(busy), 1);
        chk("start_bit_on_accept", int'(tx_serial), 0);
    endtask

    task automatic wait_done(input int maxc);
        for (int n = 0; n < maxc; n++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        chk("done_seen", int'(done), 1);
    endtask

    task automatic run_frame(input int len_in, input int L, input logic [7:0] cs);
        tbl_len = 8'(len_in);
        push_frame(L, cs);
        kick();
        wait_done((L + 3) * 10 * CPB + 20);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int dc;
        for (int i = 0; i < MAXC; i++) mem[i] = 8'h00;
        mem[0] = 8'd0; mem[1] = 8'd10; mem[2] = 8'd18;
        mem[3] = 8'd25; mem[4] = 8'd33; mem[5] = 8'd38;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", int'(tx_serial), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Nominal: 6+0+10+18+25+33+38 = 130 = 0x82
        run_frame(6, 6, 8'h82);
        // Empty table: A5 00 00
        run_frame(0, 0, 8'h00);

        // Start held through a frame; tbl_len changes mid-frame.
        // Frame 1: L=3, 3+0+10+18 = 0x1F.  Frame 2: L=2, 2+0+10 = 0x0C.
        tbl_len = 8'd3;
        push_frame(3, 8'h1F);
        push_frame(2, 8'h0C);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 tbl_len = 8'd2;
        wait_done(300);
        @(posedge clk); #1;
        chk("restart_after_done", int'(busy), 1);
        start = 1'b0;
        wait_done(260);
        repeat (3) @(posedge clk);
        #1;

        // Reset during data byte 3 (frame byte index 5).
        tbl_len = 8'd6;
        push_frame(6, 8'h82);
        kick();
        repeat (5 * 10 * CPB + 8) @(posedge clk);
        #1 reset = 1'b0;
        dc = done_cnt;
        @(posedge clk); #1;
        chk("abort_tx", int'(tx_serial), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rd_en", int'(rd_en), 0);
        chk("abort_rd_addr", int'(rd_addr), 0);
        repeat (3) @(posedge clk);
        #1;
        bq.delete(); fq.delete();
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_done_on_abort", done_cnt, dc);
        run_frame(6, 6, 8'h82);

        // Clamp: 200 -> 64 entries of 0xFF; 64 + 64*255 = 0 mod 256
        for (int i = 0; i < MAXC; i++) mem[i] = 8'hFF;
        run_frame(200, 64, 8'h00);

        chk("bytes_left", bq.size(), 0);
        chk("frames_left", fq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/knap_result_tx.md
Name: knap_result_tx

Overview:
- Reads the knapsack DP result table (cache entries 0..N-1) through a synchronous read port after the solver finishes.
- Serializes the table as a framed UART 8N1 byte stream on tx_serial. This is the transmit end of the UART link.
- Sits beside the DP engine in top; start is driven by the solver's completion and reset by the board reset.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200).
- MAX_CAP, 64: number of table entries.
- ADDR_W, 6: table address width; must satisfy 2**ADDR_W >= MAX_CAP.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-low.
- start  input  1  request a frame; sampled in IDLE only.
- tbl_len  input  8  number of entries to send; values above MAX_CAP are clamped to MAX_CAP.
- rd_addr  output  ADDR_W  table read address.
- rd_en  output  1  table read strobe.
- rd_data  input  8  table data, valid 1 cycle after rd_en.
- tx_serial  output  1  UART line, idle high.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset: reset==0 at a rising edge does all of the following.
  - tx_serial=1, busy=0, done=0, rd_en=0, rd_addr=0.
  - FSM goes to IDLE; baud and bit counters clear; checksum clears.
  - This applies mid-frame: the line returns high on the next edge and the frame is abandoned, with no done pulse.
- Frame, in order:
  - 0xA5 header.
  - L = min(tbl_len, MAX_CAP), latched when start is accepted.
  - L data bytes: table[0..L-1].
  - Checksum = (L + sum of data bytes) mod 256. The header is excluded.
- UART byte format:
  - Start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit is exactly CLKS_PER_BIT cycles.
  - Bytes go back-to-back with no idle gap between one stop bit and the next start bit.
- Frame FSM: IDLE -> HDR -> LEN -> DATA (repeats L times) -> CSUM -> FINISH -> IDLE.
  - IDLE: when start==1, latch L, clear the checksum and go to HDR.
  - The start bit of the header appears on tx_serial at the edge after start is sampled; busy rises at that same edge.
  - start is ignored while busy, including start held high through a frame.
  - After FINISH, a new frame begins only if start is sampled high in IDLE. start held high therefore restarts one cycle after done.
- Data prefetch:
  - For data byte k, rd_en is pulsed for one cycle with rd_addr=k at the first cycle of the previous byte's stop bit.
  - rd_data is captured on the following edge and added into the checksum.
  - rd_addr holds its value otherwise; rd_en is never asserted outside DATA prefetch.
  - Requires CLKS_PER_BIT >= 4.
- L==0: the frame is A5 00 00 (header, length, checksum) with no table reads.
- L==MAX_CAP: last rd_addr = MAX_CAP-1, with no address wrap.
- Arithmetic:
  - Checksum is an 8-bit register with wrap-around addition.
  - The baud counter runs 0..CLKS_PER_BIT-1.
  - The bit index runs 0..9 (start, 8 data, stop).
- done and busy:
  - done pulses for one cycle at the edge where the checksum's stop bit completes.
  - busy falls at that same edge.
  - tx_serial stays high from then on while idle.
- Latency: the frame spans exactly (L+3)*10*CLKS_PER_BIT cycles from the first start-bit cycle to done.

Test Plan:
- Nominal frame.
  - Setup: CLKS_PER_BIT=4, table = 0,10,18,25,33,38, tbl_len=6, start pulse.
  - Required: bytes A5 06 00 0A 12 19 21 26 82 decoded LSB-first, each bit 4 cycles, no gaps.
  - Required: done exactly 360 cycles after the first start bit; busy high for that whole span.
- Empty table.
  - Stimulus: tbl_len=0.
  - Required: frame A5 00 00; rd_en never asserted; done after 120 cycles.
- Clamp and wrap.
  - Stimulus: tbl_len=200, MAX_CAP=64, all entries 0xFF.
  - Required: length byte 0x40; 64 reads at addresses 0..63; checksum (64 + 64*255) mod 256 = 0x00.
- Start while busy.
  - Stimulus: start held high for a whole frame.
  - Required: only one frame in progress at a time; the second frame starts the cycle after done; the latched L is unchanged mid-frame even if tbl_len changes.
- Reset mid-frame.
  - Stimulus: reset=0 during data byte 3.
  - Required: tx_serial=1, busy=0, rd_en=0 on the next edge; no done pulse; a subsequent start produces a clean full frame.
- Read timing.
  - Check: each rd_en pulse is one cycle, at the first stop-bit cycle of the preceding byte.
  - Check: a changing rd_data at any cycle other than rd_en+1 does not alter the transmitted data.
